// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: shared types and constants for the synchronous FIFO read-side controller.
// Used by fifo_rd_skid and syn_fifo_rd_ctrl.
package syn_fifo_pkg;

    // Default word width; must match the FIFO the controller drains.
    localparam int unsigned DEFAULT_DATA_W = 128;

    // Number of entries in the output skid buffer.
    localparam int unsigned SKID_DEPTH = 2;

    // Skid occupancy, 0..SKID_DEPTH.
    typedef logic [1:0] occ_t;

    // Read-controller FSM states.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry valid/ready buffer that absorbs the FIFO's 1-cycle read latency.
// Entry 0 is always the head, so o_data comes straight from a register and stays stable
// while the downstream stalls. Writes and pops in the same cycle keep occupancy unchanged.
module fifo_rd_skid
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output occ_t              occ
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    occ_t              occ_q, occ_d;
    logic              pop;

    // Head/tail next-state: shift entry 1 into the head on a pop, append writes at the tail.
    always_comb begin
        pop    = o_valid & i_ready;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (wr_en) begin
                    ent0_d = wr_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (wr_en && pop) begin
                    ent0_d = wr_data;
                end else if (wr_en) begin
                    ent1_d = wr_data;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    if (wr_en) begin
                        ent1_d = wr_data;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Buffer registers; reset clears the head so o_data reads all-zeros out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign o_valid = (occ_q != 2'd0);
    assign o_data  = ent0_q;
    assign occ     = occ_q;

    // The controller's credit check must never let a write land on a full, stalled buffer.
    skid_no_overflow_a : assert property (
        @(posedge clk) disable iff (rst) !(wr_en && !pop && (occ_q == 2'd2))
    );

endmodule

// File: rtl/syn_fifo_rd_ctrl.sv
// syn_fifo_rd_ctrl: read-side controller for the synchronous FIFO.
// Drains FIFO words into a 2-entry skid buffer and presents them as a valid/ready stream.
// Build option SYN_FIFO_RD_BATCH_EN: when defined, IDLE waits for the FIFO to leave
// almost-empty or for an idle timeout before streaming; when undefined, any non-empty
// FIFO starts streaming and the timeout logic is not built.
module syn_fifo_rd_ctrl
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_rden,
    input  logic [DATA_W-1:0] i_rddata,
    input  logic              i_empty,
    input  logic              i_alm_empty,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy
);

    rd_state_t state_q, state_d;
    logic      inflight_q;
    occ_t      occ;
    logic      pop;
    logic [2:0] used;
    logic      credit;
    logic      go;

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data (i_rddata),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .occ     (occ)
    );

    // Credit check: buffered + in-flight words, minus this cycle's pop, must leave a free slot.
    always_comb begin
        pop    = o_valid & i_ready;
        used   = {1'b0, occ} + {2'b00, inflight_q};
        credit = (used < 3'd2) | ((used == 3'd2) & pop);
        o_rden = (state_q == STREAM) & ~i_empty & ~rst & credit;
        o_busy = (state_q == STREAM) | (occ != 2'd0) | inflight_q;
    end

`ifdef SYN_FIFO_RD_BATCH_EN
    logic [TO_W-1:0] timer_q, timer_d;
    logic            expired;

    // Start condition and idle timer: count non-empty IDLE cycles, saturating at TIMEOUT-1.
    always_comb begin
        expired = (timer_q == TO_W'(TIMEOUT - 1));
        go      = ~i_empty & (~i_alm_empty | expired);
        timer_d = timer_q;
        if ((state_q != IDLE) || i_empty || go) begin
            timer_d = '0;
        end else if (!expired) begin
            timer_d = timer_q + TO_W'(1);
        end
    end

    // Idle timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    // Without batching the FIFO is drained as soon as it holds anything.
    assign go = ~i_empty;

    logic unused_batch;
    assign unused_batch = ^{i_alm_empty, TO_W'(TIMEOUT)};
`endif

    // FSM next state: leave IDLE on the start condition, drop back as soon as the FIFO empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (i_empty) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and in-flight flag; a read issued just before reset is dropped with the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= o_rden;
        end
    end

endmodule

// File: tb/tb_syn_fifo_rd_ctrl.sv
// tb_syn_fifo_rd_ctrl: randomized bench for syn_fifo_rd_ctrl against a queue-based model
// of the FIFO and of the controller's word stream. Honours SYN_FIFO_RD_BATCH_EN.
module tb_syn_fifo_rd_ctrl;

    localparam int unsigned DW      = 128;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned TO_W    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          o_rden;
    logic [DW-1:0] i_rddata;
    logic          i_empty;
    logic          i_alm_empty;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;

    always #5 clk = ~clk;

    syn_fifo_rd_ctrl #(
        .DATA_W  (DW),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .o_rden      (o_rden),
        .i_rddata    (i_rddata),
        .i_empty     (i_empty),
        .i_alm_empty (i_alm_empty),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: storage queue plus the registered read port.
    logic [DW-1:0] fq[$];
    bit            rd_q = 1'b0;
    logic [DW-1:0] rd_word = '0;
    int unsigned   seq = 0;

    // Controller model: streaming flag, idle timer, word queue seen downstream, in-flight word.
    bit            m_stream    = 1'b0;
    int            m_timer     = 0;
    logic [DW-1:0] m_buf[$];
    bit            m_infl      = 1'b0;
    logic [DW-1:0] m_infl_data = '0;
    bit            m_zero_head = 1'b1;

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: entered and left #1 after a rising edge.
    task automatic run_cycle(input int n_push, input bit ready, input bit rst_in);
        bit pop;
        bit exp_rden;
        bit go;
        i_rddata = rd_q ? rd_word : {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < n_push; i++) begin
            fq.push_back({$urandom(), $urandom(), $urandom(), seq});
            seq++;
        end
        i_empty     = (fq.size() == 0);
        i_alm_empty = (fq.size() <= 2);
        i_ready     = ready;
        rst         = rst_in;
        #2;
        pop      = (m_buf.size() != 0) && ready;
        exp_rden = m_stream && !i_empty && !rst_in &&
                   ((int'(m_buf.size()) + int'(m_infl) - int'(pop)) < 2);
        check_eq("o_rden", DW'(o_rden), DW'(exp_rden));
        check_eq("o_valid", DW'(o_valid), DW'(m_buf.size() != 0));
        check_eq("o_busy", DW'(o_busy), DW'(m_stream || (m_buf.size() != 0) || m_infl));
        if (m_buf.size() != 0) begin
            check_eq("o_data", o_data, m_buf[0]);
        end else if (m_zero_head) begin
            check_eq("o_data_rst", o_data, '0);
        end
        // FIFO side: a read sampled on the coming edge is presented the cycle after.
        rd_q = exp_rden;
        if (exp_rden) begin
            rd_word = fq.pop_front();
        end
        // Controller side.
        if (rst_in) begin
            m_buf.delete();
            m_infl      = 1'b0;
            m_stream    = 1'b0;
            m_timer     = 0;
            m_zero_head = 1'b1;
        end else begin
            if (pop) begin
                void'(m_buf.pop_front());
            end
            if (m_infl) begin
                m_buf.push_back(m_infl_data);
                m_zero_head = 1'b0;
            end
            m_infl      = exp_rden;
            m_infl_data = rd_word;
            if (!m_stream) begin
`ifdef SYN_FIFO_RD_BATCH_EN
                go = !i_empty && (!i_alm_empty || (m_timer == int'(TIMEOUT) - 1));
`else
                go = !i_empty;
`endif
                if (i_empty || go) begin
                    m_timer = 0;
                end else if (m_timer < int'(TIMEOUT) - 1) begin
                    m_timer++;
                end
                m_stream = go;
            end else if (i_empty) begin
                m_stream = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        bit  rdy;
        rst         = 1'b1;
        i_ready     = 1'b0;
        i_empty     = 1'b1;
        i_alm_empty = 1'b1;
        i_rddata    = '0;
        @(posedge clk);
        #1;
        repeat (3) run_cycle(0, 1'b0, 1'b1);

        // Back-to-back streaming of 8 words.
        run_cycle(8, 1'b1, 1'b0);
        repeat (19) run_cycle(0, 1'b1, 1'b0);

        // Backpressure in the middle of a 6-word stream.
        run_cycle(6, 1'b1, 1'b0);
        repeat (4) run_cycle(0, 1'b1, 1'b0);
        repeat (5) run_cycle(0, 1'b0, 1'b0);
        repeat (15) run_cycle(0, 1'b1, 1'b0);

        // Lone word: drained by the idle timeout when batching is built in.
        run_cycle(1, 1'b1, 1'b0);
        repeat (30) run_cycle(0, 1'b1, 1'b0);

        // FIFO empties after 3 reads.
        run_cycle(3, 1'b1, 1'b0);
        repeat (12) run_cycle(0, 1'b1, 1'b0);

        // Reset for 3 cycles while words are buffered and in flight.
        run_cycle(8, 1'b0, 1'b0);
        repeat (3) run_cycle(0, 1'b1, 1'b0);
        repeat (3) run_cycle(0, 1'b1, 1'b1);
        repeat (20) run_cycle(0, 1'b1, 1'b0);

        // Random traffic with toggling ready and rare resets.
        for (int c = 0; c < 3000; c++) begin
            n   = (fq.size() < 16 && $urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3)) : 0;
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) begin
                repeat (3) run_cycle(n, rdy, 1'b1);
            end else begin
                run_cycle(n, rdy, 1'b0);
            end
        end

        repeat (60) run_cycle(0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
